// File: rtl/bcd_mux_counter.sv
// -----------------------------------------------------------------------------
// bcd_mux_counter
//
// Purpose:
//   N-digit BCD up/down counter that drives a multiplexed, common-anode
//   7-segment display. Everything runs on one clock. The count rate and the
//   digit scan rate come from internal clock-enable prescalers, so the block
//   never creates a derived clock. The raw BCD value and a one-cycle wrap
//   pulse are exported so that several counters can be chained.
//
// Parameters:
//   DIGITS    number of BCD digits / anodes (1..8)
//   TICK_DIV  clk cycles per count step (>= 2)
//   SCAN_DIV  clk cycles per display digit slot (>= 2)
//
// Ports:
//   clk        in   1          system clock, all logic on posedge
//   rst        in   1          synchronous, active-high reset
//   en         in   1          count enable, only looked at on tick cycles
//   up_dn      in   1          1 = count up, 0 = count down
//   clr        in   1          synchronous clear of the count value
//   seg        out  7          segments {a,b,c,d,e,f,g}, active low, registered
//   sel        out  DIGITS     anodes, active low, one-hot-low, registered
//   bcd_value  out  4*DIGITS   digit k in bits [4k+3:4k], digit 0 = LSD
//   carry      out  1          one-cycle pulse after a full wrap
//
// Configuration macro:
//   LEADING_ZERO_BLANK_EN  when defined, a zero digit k>0 whose higher digits
//                          are also all zero is blanked while selected.
//                          Digit 0 is always shown.
// -----------------------------------------------------------------------------
module bcd_mux_counter #(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 50000000,
    parameter int SCAN_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up_dn,
    input  logic                  clr,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     sel,
    output logic [4*DIGITS-1:0]   bcd_value,
    output logic                  carry
);

    localparam int TICK_W = $clog2(TICK_DIV);
    localparam int SCAN_W = $clog2(SCAN_DIV);
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [6:0] SEG_OFF  = 7'b1111111;
    localparam logic [6:0] SEG_DASH = 7'b1111110;

    // Active-low segment decode for one BCD digit.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'b0000001;
            4'd1:    seg_decode = 7'b1001111;
            4'd2:    seg_decode = 7'b0010010;
            4'd3:    seg_decode = 7'b0000110;
            4'd4:    seg_decode = 7'b1001100;
            4'd5:    seg_decode = 7'b0100100;
            4'd6:    seg_decode = 7'b0100000;
            4'd7:    seg_decode = 7'b0001111;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0000100;
            default: seg_decode = SEG_DASH;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Count-rate prescaler: free running, independent of en and clr.
    // ------------------------------------------------------------------
    logic [TICK_W-1:0] tick_cnt;
    logic              tick;

    assign tick = (tick_cnt == TICK_W'(TICK_DIV - 1));

    // NOTE: sequential state is always assigned with <= so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TICK_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // BCD digit chain.
    // A step ripples from digit 0 upward for as long as each digit wraps
    // (9->0 going up, 0->9 going down). If the ripple survives the top digit
    // the whole counter wrapped and carry fires on the next cycle.
    // ------------------------------------------------------------------
    logic [3:0] digit      [DIGITS];
    logic [3:0] digit_step [DIGITS];
    logic       step_wrap;

    // NOTE: every output of a combinational block gets a default before any
    // conditional logic, otherwise a missed branch infers a latch.
    always_comb begin
        logic ripple;
        digit_step = digit;
        ripple     = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (ripple) begin
                if (up_dn) begin
                    if (digit[k] >= 4'd9) begin
                        digit_step[k] = 4'd0;
                    end else begin
                        digit_step[k] = digit[k] + 4'd1;
                        ripple        = 1'b0;
                    end
                end else begin
                    if (digit[k] == 4'd0) begin
                        digit_step[k] = 4'd9;
                    end else begin
                        digit_step[k] = digit[k] - 4'd1;
                        ripple        = 1'b0;
                    end
                end
            end
        end
        step_wrap = ripple;
    end

    // NOTE: the digit array is a handful of flops, not a RAM, so it is reset
    // element by element; never do this for a real memory macro.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DIGITS; k++) begin
                digit[k] <= 4'd0;
            end
            carry <= 1'b0;
        end else begin
            carry <= 1'b0;
            if (clr) begin
                // Clear wins over a coinciding step and suppresses its carry.
                for (int k = 0; k < DIGITS; k++) begin
                    digit[k] <= 4'd0;
                end
            end else if (tick && en) begin
                digit <= digit_step;
                carry <= step_wrap;
            end
        end
    end

    always_comb begin
        bcd_value = '0;
        for (int k = 0; k < DIGITS; k++) begin
            bcd_value[4*k +: 4] = digit[k];
        end
    end

    // ------------------------------------------------------------------
    // Display scan: prescaler plus digit index.
    // ------------------------------------------------------------------
    logic [SCAN_W-1:0] scan_cnt;
    logic [IDX_W-1:0]  scan_idx;
    logic              scan_wrap;

    assign scan_wrap = (scan_cnt == SCAN_W'(SCAN_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt <= '0;
            scan_idx <= '0;
        end else if (scan_wrap) begin
            scan_cnt <= '0;
            if (scan_idx == IDX_W'(DIGITS - 1)) begin
                scan_idx <= '0;
            end else begin
                scan_idx <= scan_idx + IDX_W'(1);
            end
        end else begin
            scan_cnt <= scan_cnt + SCAN_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Leading-zero blanking mask: blank[k] is set when digit k and every
    // digit above it are zero. Digit 0 is never blanked.
    // ------------------------------------------------------------------
    logic [DIGITS-1:0] blank;

`ifdef LEADING_ZERO_BLANK_EN
    always_comb begin
        logic upper_zero;
        blank      = '0;
        upper_zero = 1'b1;
        for (int k = DIGITS - 1; k > 0; k--) begin
            upper_zero = upper_zero && (digit[k] == 4'd0);
            blank[k]   = upper_zero;
        end
    end
`else
    assign blank = '0;
`endif

    // Mux out the digit currently being scanned. A compare loop keeps the
    // select in range for digit counts that are not a power of two.
    logic [3:0] cur_digit;
    logic       cur_blank;

    always_comb begin
        cur_digit = 4'd0;
        cur_blank = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (scan_idx == IDX_W'(k)) begin
                cur_digit = digit[k];
                cur_blank = blank[k];
            end
        end
    end

    // sel and seg come from the same scan index in the same register stage,
    // so anode and segment pattern always switch on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel <= '1;
            seg <= SEG_OFF;
        end else begin
            sel <= ~(DIGITS'(1) << scan_idx);
            seg <= cur_blank ? SEG_OFF : seg_decode(cur_digit);
        end
    end

endmodule
